wbmstr_burst: RTL and testbench

Parametrised single-lane Wishbone master, the next generation of the team's FIFO-driven wbmstr. It pops command words from the DP0 FIFO, runs classic Wishbone cycles, and pushes replies to the DP1 FIFO. It adds three features: burst reads (repeated or auto-incrementing address), a per-access ack timeout, and configurable write replies. Saturating read-error, write-error and timeout counters are exposed for the control register bank.

---
 rtl/wbmstr_burst.sv | 170 +++++++++++++++++
 tb/tb_wbmstr_burst.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbmstr_burst.sv
// FIFO-driven Wishbone master: pops command words, runs single or burst accesses,
// pushes reply words, and keeps saturating error/timeout counters.
module wbmstr_burst #(
    parameter int GpifWidth        = 32,
    parameter int WbDataWidth      = 16,
    parameter int WbAddWidth       = 12,
    parameter int G_TIMEOUT_CYCLES = 255,
    parameter int G_ADDR_INCR      = 0,
    parameter int G_WR_REPLY       = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   wbm_cyc_o,
    output logic                   wbm_stb_o,
    output logic                   wbm_we_o,
    output logic [WbAddWidth-1:0]  wbm_adr_o,
    output logic [WbDataWidth-1:0] wbm_dt_o,
    input  logic [WbDataWidth-1:0] wbm_dt_i,
    input  logic                   wbm_ack_i,
    input  logic                   wbm_err_i,
    input  logic [GpifWidth-1:0]   dp0_dt_i,
    input  logic                   dp0_epty_i,
    output logic                   dp0_rd_o,
    output logic [GpifWidth-1:0]   dp1_dt_o,
    input  logic                   dp1_full_i,
    output logic                   dp1_wr_o,
    output logic                   busy_o,
    output logic [WbDataWidth-1:0] rderrcntr_o,
    output logic [WbDataWidth-1:0] wrerrcntr_o,
    output logic [WbDataWidth-1:0] tocntr_o,
    input  logic                   rst_rderrcntr_i,
    input  logic                   rst_wrerrcntr_i,
    input  logic                   rst_tocntr_i
);
    localparam int AdrLo    = WbDataWidth;
    localparam int AdrHi    = WbAddWidth + WbDataWidth - 1;
    localparam int TW       = (G_TIMEOUT_CYCLES > 1) ? $clog2(G_TIMEOUT_CYCLES) : 1;
    localparam int ToLastI  = (G_TIMEOUT_CYCLES > 0) ? G_TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TW-1:0] TO_LAST = TW'(ToLastI);
    localparam logic [WbAddWidth-1:0] ADR_STEP = WbAddWidth'((G_ADDR_INCR != 0) ? 1 : 0);

    // NEXT is the one-cycle turnaround after a pushed reply before the next beat or IDLE.
    typedef enum logic [1:0] {IDLE, CYCLE, REPLY, NEXT} state_t;

    state_t                 state;
    logic [TW-1:0]          to_cnt;
    logic [WbDataWidth-1:0] beats;
    logic                   beat_ok;

    logic                   c_we, c_burst;
    logic [WbAddWidth-1:0]  c_adr;
    logic [WbDataWidth-1:0] c_dat;
    logic                   resp_err, resp_ack, resp_to, reply_due;
    logic [GpifWidth-1:0]   reply_word;
    logic                   unused_cmd_bits;

    assign c_we    = dp0_dt_i[GpifWidth-1];
    assign c_burst = dp0_dt_i[GpifWidth-2] & ~c_we;
    assign c_adr   = dp0_dt_i[AdrHi:AdrLo];
    assign c_dat   = dp0_dt_i[WbDataWidth-1:0];
    // Command bits between the address field and the flag bits carry no meaning.
    assign unused_cmd_bits = ^dp0_dt_i;

    assign busy_o   = (state != IDLE);
    assign dp1_wr_o = (state == REPLY) && !dp1_full_i;

    always_comb begin
        resp_err  = (state == CYCLE) && wbm_stb_o && wbm_err_i;
        resp_ack  = (state == CYCLE) && wbm_stb_o && wbm_ack_i && !wbm_err_i;
        resp_to   = (G_TIMEOUT_CYCLES != 0) && (state == CYCLE) && wbm_stb_o &&
                    !wbm_ack_i && !wbm_err_i && (to_cnt == TO_LAST);
        reply_due = !wbm_we_o || (G_WR_REPLY != 0) || !resp_ack;
        reply_word = '0;
        reply_word[GpifWidth-1] = resp_err;
        reply_word[GpifWidth-2] = resp_to;
        reply_word[AdrHi:AdrLo] = wbm_adr_o;
        if (resp_ack && !wbm_we_o)
            reply_word[WbDataWidth-1:0] = wbm_dt_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dt_o  <= '0;
            dp0_rd_o  <= 1'b0;
            dp1_dt_o  <= '0;
            to_cnt    <= '0;
            beats     <= '0;
            beat_ok   <= 1'b0;
        end else begin
            dp0_rd_o <= 1'b0;
            case (state)
                IDLE: begin
                    // The word stays visible until the pop edge, so skip the cycle of the pop.
                    if (!dp0_epty_i && !dp0_rd_o) begin
                        dp0_rd_o <= 1'b1;
                        if (!(c_burst && c_dat == '0)) begin
                            state     <= CYCLE;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_we_o  <= c_we;
                            wbm_adr_o <= c_adr;
                            wbm_dt_o  <= c_we ? c_dat : '0;
                            beats     <= c_burst ? c_dat : WbDataWidth'(1);
                            to_cnt    <= '0;
                        end
                    end
                end
                CYCLE: begin
                    if (resp_err || resp_ack || resp_to) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_dt_o  <= '0;
                        beat_ok   <= resp_ack;
                        dp1_dt_o  <= reply_word;
                        state     <= reply_due ? REPLY : IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                REPLY: begin
                    if (!dp1_full_i)
                        state <= NEXT;
                end
                NEXT: begin
                    if (beat_ok && beats != WbDataWidth'(1)) begin
                        beats     <= beats - WbDataWidth'(1);
                        wbm_adr_o <= wbm_adr_o + ADR_STEP;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        to_cnt    <= '0;
                        state     <= CYCLE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clear beats a coincident increment.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rderrcntr_o <= '0;
            wrerrcntr_o <= '0;
            tocntr_o    <= '0;
        end else begin
            if (rst_rderrcntr_i)
                rderrcntr_o <= '0;
            else if (resp_err && !wbm_we_o && !(&rderrcntr_o))
                rderrcntr_o <= rderrcntr_o + WbDataWidth'(1);

            if (rst_wrerrcntr_i)
                wrerrcntr_o <= '0;
            else if (resp_err && wbm_we_o && !(&wrerrcntr_o))
                wrerrcntr_o <= wrerrcntr_o + WbDataWidth'(1);

            if (rst_tocntr_i)
                tocntr_o <= '0;
            else if (resp_to && !(&tocntr_o))
                tocntr_o <= tocntr_o + WbDataWidth'(1);
        end
    end
endmodule

// File: tb/tb_wbmstr_burst.sv
// Bench for wbmstr_burst: FIFO/slave models driven from scenario tasks, replies and
// counters compared against a transaction-level reference model.
module tb_wbmstr_burst;
    localparam int GW = 32, DW = 8, AW = 12, TO = 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dt_o;
    logic [DW-1:0] wbm_dt_i = '0;
    logic          wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
    logic [GW-1:0] dp0_dt_i = '0;
    logic          dp0_epty_i = 1'b1;
    logic          dp0_rd_o;
    logic [GW-1:0] dp1_dt_o;
    logic          dp1_full_i = 1'b0;
    logic          dp1_wr_o, busy_o;
    logic [DW-1:0] rderrcntr_o, wrerrcntr_o, tocntr_o;
    logic          rst_rderrcntr_i, rst_wrerrcntr_i, rst_tocntr_i;

    always #5 clk = ~clk;

    wbmstr_burst #(.GpifWidth(GW), .WbDataWidth(DW), .WbAddWidth(AW),
                   .G_TIMEOUT_CYCLES(TO), .G_ADDR_INCR(1), .G_WR_REPLY(0)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dt_o(wbm_dt_o), .wbm_dt_i(wbm_dt_i),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .dp0_dt_i(dp0_dt_i), .dp0_epty_i(dp0_epty_i), .dp0_rd_o(dp0_rd_o),
        .dp1_dt_o(dp1_dt_o), .dp1_full_i(dp1_full_i), .dp1_wr_o(dp1_wr_o),
        .busy_o(busy_o),
        .rderrcntr_o(rderrcntr_o), .wrerrcntr_o(wrerrcntr_o), .tocntr_o(tocntr_o),
        .rst_rderrcntr_i(rst_rderrcntr_i), .rst_wrerrcntr_i(rst_wrerrcntr_i),
        .rst_tocntr_i(rst_tocntr_i)
    );

    int n_chk = 0, n_pass = 0;

    // stimulus knobs (written by the scenario tasks only)
    logic [GW-1:0] cmd_arr [1024];
    int  cmd_wr = 0;
    int  sl_ws = 0, sl_errb = 0, beat_base = 0, salt = 0;
    bit  sl_allerr = 0, full_force = 0, bp_rand = 0;

    // FIFO / slave side (written by the driver process only)
    int  cmd_rd = 0, sl_cnt = 0, sl_beat = 0;

    // observations (written by the sampler only)
    logic [GW-1:0] rep_arr [2048];
    int  rep_cyc [2048];
    int  rep_n = 0, cyc_n = 0, stb_n = 0, acc_n = 0, pop_n = 0;
    bit  stb_q = 0, last_we = 0;
    logic [AW-1:0] last_adr = '0;
    logic [DW-1:0] last_dt = '0;

    // reference model state
    logic [GW-1:0] exp_arr [2048];
    int  exp_n = 0, m_rd = 0, m_wr = 0, m_to = 0, m_b = 0;
    int  rep0 = 0, acc0 = 0, stb0 = 0, pop0 = 0;

    function automatic logic [DW-1:0] rdata(logic [AW-1:0] a);
        int v;
        v = int'(a) * 37 + salt;
        return v[DW-1:0];
    endfunction

    function automatic logic [GW-1:0] mk(bit we, bit bu, logic [AW-1:0] a, logic [DW-1:0] d);
        return {we, bu, 10'b0, a, d};
    endfunction

    // Inputs change 1 time unit after the active edge; dp0 is popped in the cycle rd is high.
    always @(posedge clk) begin
        #1;
        if (dp0_rd_o) cmd_rd++;
        dp0_epty_i = (cmd_rd == cmd_wr);
        dp0_dt_i   = cmd_arr[cmd_rd % 1024];
        dp1_full_i = bp_rand ? ($urandom_range(0, 2) == 0) : full_force;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dt_i  = '0;
        if (wbm_stb_o) begin
            sl_cnt++;
            if (sl_cnt == sl_ws + 1) begin
                sl_beat++;
                if (sl_allerr || (sl_beat - beat_base == sl_errb)) wbm_err_i = 1'b1;
                else begin
                    wbm_ack_i = 1'b1;
                    wbm_dt_i  = rdata(wbm_adr_o);
                end
            end
        end else begin
            sl_cnt = 0;
        end
    end

    always @(negedge clk) begin
        cyc_n++;
        if (dp1_wr_o) begin
            rep_arr[rep_n] = dp1_dt_o;
            rep_cyc[rep_n] = cyc_n;
            rep_n++;
        end
        if (wbm_stb_o) begin
            stb_n++;
            if (!stb_q) acc_n++;
            last_adr = wbm_adr_o;
            last_dt  = wbm_dt_o;
            last_we  = wbm_we_o;
        end
        stb_q = wbm_stb_o;
        if (dp0_rd_o) pop_n++;
    end

    // Transaction-level model: one command -> expected replies and counter events.
    task automatic model_cmd(input logic [GW-1:0] c);
        bit we, bu, er, to;
        int n;
        logic [AW-1:0] ad;
        logic [DW-1:0] d;
        we = c[GW-1];
        bu = c[GW-2] && !we;
        n  = bu ? int'(c[DW-1:0]) : 1;
        for (int i = 0; i < n; i++) begin
            ad = AW'((int'(c[AW+DW-1:DW]) + i) % (1 << AW));
            to = (sl_ws >= TO);
            er = 0;
            d  = '0;
            if (!to) begin
                m_b++;
                er = sl_allerr || (m_b == sl_errb);
                if (!er && !we) d = rdata(ad);
            end
            if (er && we) m_wr++;
            if (er && !we) m_rd++;
            if (to) m_to++;
            if (!we || er || to) begin
                exp_arr[exp_n] = {er, to, 10'b0, ad, d};
                exp_n++;
            end
            if (er || to) break;
        end
    endtask

    task automatic push_cmd(input logic [GW-1:0] c);
        cmd_arr[cmd_wr % 1024] = c;
        cmd_wr++;
        model_cmd(c);
    endtask

    task automatic wait_idle(input string nm);
        int q = 0, t = 0;
        while (q < 3 && t < 6000) begin
            @(negedge clk);
            t++;
            if (cmd_rd == cmd_wr && !busy_o && !dp0_rd_o) q++;
            else q = 0;
        end
        if (q < 3) begin
            n_chk++;
            $display("FAIL %s: idle wait expired, busy=%0b required 0", nm, busy_o);
        end
    endtask

    task automatic begin_test();
        exp_n = 0; m_rd = 0; m_wr = 0; m_to = 0; m_b = 0;
        beat_base = sl_beat;
        rep0 = rep_n; acc0 = acc_n; stb0 = stb_n; pop0 = pop_n;
        rst_rderrcntr_i = 1; rst_wrerrcntr_i = 1; rst_tocntr_i = 1;
        @(negedge clk);
        rst_rderrcntr_i = 0; rst_wrerrcntr_i = 0; rst_tocntr_i = 0;
    endtask

    task automatic test_reset();
        logic [127:0] v;
        rst_i = 1;
        rst_rderrcntr_i = 0; rst_wrerrcntr_i = 0; rst_tocntr_i = 0;
        repeat (3) @(negedge clk);
        v = {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dt_o, dp0_rd_o, dp1_dt_o,
             dp1_wr_o, busy_o, rderrcntr_o, wrerrcntr_o, tocntr_o};
        n_chk++;
        if (v !== '0) $display("FAIL reset_outputs: got %h required 0", v);
        else n_pass++;
        rst_i = 0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        sl_ws = 2; sl_errb = 0; salt = 8'h55;
        begin_test();
        push_cmd(mk(0, 0, 12'h012, 8'h00));
        wait_idle("single_read");
        n_chk++;
        if (rep_n - rep0 !== 1 || rep_arr[rep0] !== 32'h0000_12EF)
            $display("FAIL single_read_reply: count %0d word %h required 1 word 000012ef", rep_n - rep0, rep_arr[rep0]);
        else n_pass++;
        n_chk++;
        if (pop_n - pop0 !== 1) $display("FAIL single_read_pop: rd cycles %0d required 1", pop_n - pop0);
        else n_pass++;
        n_chk++;
        if (stb_n - stb0 !== 3) $display("FAIL single_read_stb: stb cycles %0d required 3", stb_n - stb0);
        else n_pass++;
    endtask

    task automatic test_single_write();
        sl_ws = 0; sl_errb = 0;
        begin_test();
        push_cmd(mk(1, 1, 12'h034, 8'hA5));
        wait_idle("single_write");
        n_chk++;
        if (last_adr !== 12'h034 || last_dt !== 8'hA5 || last_we !== 1'b1)
            $display("FAIL single_write_bus: adr %h dt %h we %0b required 034 a5 1", last_adr, last_dt, last_we);
        else n_pass++;
        n_chk++;
        if (rep_n - rep0 !== exp_n || acc_n - acc0 !== 1)
            $display("FAIL single_write_noreply: replies %0d accesses %0d required %0d 1", rep_n - rep0, acc_n - acc0, exp_n);
        else n_pass++;
    endtask

    task automatic test_burst_wrap();
        logic [AW-1:0] want [4];
        want[0] = 12'hFFE; want[1] = 12'hFFF; want[2] = 12'h000; want[3] = 12'h001;
        sl_ws = 0; sl_errb = 0; salt = 3;
        begin_test();
        push_cmd(mk(0, 1, 12'hFFE, 8'd4));
        wait_idle("burst_wrap");
        n_chk++;
        if (rep_n - rep0 !== 4) $display("FAIL burst_count: got %0d required 4", rep_n - rep0);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (rep_arr[rep0+i] !== exp_arr[i] || rep_arr[rep0+i][AW+DW-1:DW] !== want[i])
                $display("FAIL burst_beat%0d: got %h required %h", i, rep_arr[rep0+i], exp_arr[i]);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (rep_cyc[rep0+i+1] - rep_cyc[rep0+i] !== 3)
                $display("FAIL burst_spacing%0d: got %0d required 3", i, rep_cyc[rep0+i+1] - rep_cyc[rep0+i]);
            else n_pass++;
        end
    endtask

    task automatic test_err_burst();
        sl_ws = 0; sl_errb = 2;
        begin_test();
        push_cmd(mk(0, 1, 12'h200, 8'd4));
        wait_idle("err_burst");
        n_chk++;
        if (rep_n - rep0 !== 2 || rep_arr[rep0+1] !== 32'h8002_0100 || rep_arr[rep0] !== exp_arr[0])
            $display("FAIL err_burst_replies: count %0d second %h required 2 80020100", rep_n - rep0, rep_arr[rep0+1]);
        else n_pass++;
        n_chk++;
        if (rderrcntr_o !== 8'd1 || acc_n - acc0 !== 2)
            $display("FAIL err_burst_cntr: rderr %0d accesses %0d required 1 2", rderrcntr_o, acc_n - acc0);
        else n_pass++;
        sl_errb = 0;
    endtask

    task automatic test_timeout();
        sl_ws = TO - 1;
        begin_test();
        push_cmd(mk(0, 0, 12'h300, 8'h00));
        wait_idle("ack_at_limit");
        n_chk++;
        if (stb_n - stb0 !== TO || rep_arr[rep0] !== exp_arr[0] || tocntr_o !== 8'd0)
            $display("FAIL ack_at_limit: stb %0d word %h to %0d required %0d %h 0", stb_n - stb0, rep_arr[rep0], tocntr_o, TO, exp_arr[0]);
        else n_pass++;
        sl_ws = 1000;
        begin_test();
        push_cmd(mk(0, 0, 12'h301, 8'h00));
        wait_idle("timeout");
        n_chk++;
        if (stb_n - stb0 !== TO) $display("FAIL timeout_stb: got %0d required %0d", stb_n - stb0, TO);
        else n_pass++;
        n_chk++;
        if (rep_n - rep0 !== 1 || rep_arr[rep0] !== 32'h4003_0100 || tocntr_o !== 8'd1)
            $display("FAIL timeout_reply: count %0d word %h tocntr %0d required 1 40030100 1", rep_n - rep0, rep_arr[rep0], tocntr_o);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad = 0, rel;
        sl_ws = 0; salt = 9;
        begin_test();
        full_force = 1;
        push_cmd(mk(0, 0, 12'h0AA, 8'h00));
        push_cmd(mk(0, 0, 12'h0BB, 8'h00));
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rep_n != rep0 || acc_n != acc0 + 1 || dp1_dt_o !== exp_arr[0]) bad++;
        end
        n_chk++;
        if (bad !== 0) $display("FAIL backpressure_hold: bad cycles %0d required 0", bad);
        else n_pass++;
        @(negedge clk);
        full_force = 0;
        #1 rel = cyc_n;
        wait_idle("backpressure");
        n_chk++;
        if (rep_n - rep0 !== 2 || rep_arr[rep0] !== exp_arr[0] || rep_arr[rep0+1] !== exp_arr[1])
            $display("FAIL backpressure_replies: count %0d first %h required 2 %h", rep_n - rep0, rep_arr[rep0], exp_arr[0]);
        else n_pass++;
        n_chk++;
        if (rep_cyc[rep0] !== rel + 1) $display("FAIL backpressure_release: push cycle %0d required %0d", rep_cyc[rep0], rel + 1);
        else n_pass++;
    endtask

    task automatic test_random();
        int wsv [4];
        bit we, bu;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        wsv[0] = 0; wsv[1] = 1; wsv[2] = 3; wsv[3] = TO;
        for (int r = 0; r < 3; r++) begin
            sl_ws = wsv[$urandom_range(0, 3)];
            sl_errb = $urandom_range(0, 6);
            salt = $urandom_range(0, 255);
            begin_test();
            bp_rand = 1;
            for (int k = 0; k < 15; k++) begin
                we = ($urandom_range(0, 2) == 0);
                bu = $urandom_range(0, 1);
                a  = $urandom_range(0, 1) ? AW'($urandom) : AW'(12'hFFC + $urandom_range(0, 3));
                d  = (bu && !we) ? DW'($urandom_range(0, 4)) : DW'($urandom);
                push_cmd(mk(we, bu, a, d));
            end
            wait_idle("random");
            bp_rand = 0;
            n_chk++;
            if (rep_n - rep0 !== exp_n) $display("FAIL random%0d_count: got %0d required %0d", r, rep_n - rep0, exp_n);
            else n_pass++;
            for (int i = 0; i < exp_n; i++) begin
                n_chk++;
                if (rep_arr[rep0+i] !== exp_arr[i])
                    $display("FAIL random%0d_reply%0d: got %h required %h", r, i, rep_arr[rep0+i], exp_arr[i]);
                else n_pass++;
            end
            n_chk++;
            if (rderrcntr_o !== DW'(m_rd) || wrerrcntr_o !== DW'(m_wr) || tocntr_o !== DW'(m_to))
                $display("FAIL random%0d_cntrs: got %0d/%0d/%0d required %0d/%0d/%0d", r,
                         rderrcntr_o, wrerrcntr_o, tocntr_o, m_rd, m_wr, m_to);
            else n_pass++;
        end
        sl_errb = 0;
    endtask

    task automatic test_saturate_and_clear();
        sl_ws = 0; sl_allerr = 1;
        begin_test();
        for (int k = 0; k < (1 << DW) + 3; k++) push_cmd(mk(1, 0, AW'(k), DW'(k)));
        wait_idle("saturate");
        n_chk++;
        if (wrerrcntr_o !== 8'hFF || rep_n - rep0 !== (1 << DW) + 3)
            $display("FAIL wrerr_saturate: cntr %h replies %0d required ff %0d", wrerrcntr_o, rep_n - rep0, (1 << DW) + 3);
        else n_pass++;
        rst_wrerrcntr_i = 1;
        push_cmd(mk(1, 0, 12'h040, 8'h01));
        wait_idle("clear_same_cycle");
        rst_wrerrcntr_i = 0;
        n_chk++;
        if (wrerrcntr_o !== 8'h00) $display("FAIL clear_wins: got %h required 00", wrerrcntr_o);
        else n_pass++;
        push_cmd(mk(1, 0, 12'h041, 8'h02));
        wait_idle("after_clear");
        n_chk++;
        if (wrerrcntr_o !== 8'h01) $display("FAIL count_after_clear: got %h required 01", wrerrcntr_o);
        else n_pass++;
        sl_allerr = 0;
    endtask

    task automatic test_rst_mid();
        int t = 0;
        sl_ws = 1000;
        begin_test();
        push_cmd(mk(0, 1, 12'h100, 8'd3));
        while (!wbm_stb_o && t < 20) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        rst_i = 1;
        @(negedge clk);
        n_chk++;
        if ({wbm_cyc_o, wbm_stb_o, dp1_wr_o, busy_o} !== 4'b0)
            $display("FAIL rst_mid: cyc/stb/wr/busy %b required 0000", {wbm_cyc_o, wbm_stb_o, dp1_wr_o, busy_o});
        else n_pass++;
        rst_i = 0;
        repeat (20) @(negedge clk);
        n_chk++;
        if (rep_n !== rep0 || busy_o !== 1'b0 || acc_n - acc0 !== 1)
            $display("FAIL rst_mid_drop: replies %0d busy %0b accesses %0d required 0 0 1", rep_n - rep0, busy_o, acc_n - acc0);
        else n_pass++;
        sl_ws = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_burst_wrap();
        test_err_burst();
        test_timeout();
        test_backpressure();
        test_random();
        test_saturate_and_clear();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
